// File: rtl/parking_pkg.sv
// Shared constants for the parking gate arbiter and the password controller.
package parking_pkg;

    // FSM state encodings (3-bit, kept as plain constants for legacy tools)
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_AUTH = 3'd1;
    localparam logic [2:0] OPEN_IN   = 3'd2;
    localparam logic [2:0] OPEN_OUT  = 3'd3;
    localparam logic [2:0] CLOSING   = 3'd4;

    // Grant-lane identifiers used by the round-robin pointer
    localparam logic ENTRY = 1'b0;
    localparam logic EXIT  = 1'b1;

    // Password-accepted code shared with the upstream password controller
    localparam logic [2:0] PASS_OK = 3'b101;

    // Timer width: clog2 of the larger timeout, never narrower than one bit
    function automatic int tmr_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/parking_gate_arbiter_park_timer.sv
// park_timer: clear/enable saturating up-counter with terminal-count compare.
module park_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == tc_val);

endmodule

// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between the entry and exit
// lanes, tracks lot occupancy and force-closes on timeout.
// Optional statistics counters are built when PARK_STATS_EN is defined.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 8,
    parameter int CNT_W       = 4,
    parameter int AUTH_CYCLES = 32,
    parameter int OPEN_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             entry_auth,
    input  logic             car_passed,
    output logic             gate_open,
    output logic             entry_grant,
    output logic             exit_grant,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             timeout_err
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]      total_entries,
    output logic [15:0]      denied_full
`endif
);

    localparam int TMR_W = tmr_width(AUTH_CYCLES, OPEN_CYCLES);
    localparam logic [TMR_W-1:0] AUTH_TC = TMR_W'(AUTH_CYCLES - 1);
    localparam logic [TMR_W-1:0] OPEN_TC = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);

    logic [2:0]       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             full_q, full_d;
    logic             gate_open_q, gate_open_d;
    logic             entry_grant_q, entry_grant_d;
    logic             exit_grant_q, exit_grant_d;
    logic             timeout_err_q, timeout_err_d;
    logic             counted_entry;

    logic [TMR_W-1:0] tmr_cnt;
    logic [TMR_W-1:0] tmr_tc_val;
    logic             tmr_tc;
    logic             tmr_clr;

    // Terminal count depends on whether we are waiting for auth or holding open
    assign tmr_tc_val = (state_q == WAIT_AUTH) ? AUTH_TC : OPEN_TC;
    assign tmr_clr    = (state_d != state_q);

    park_timer #(.W(TMR_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (tmr_clr),
        .en     (1'b1),
        .tc_val (tmr_tc_val),
        .cnt    (tmr_cnt),
        .tc     (tmr_tc)
    );

    // Arbitration, FSM next state and occupancy update
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        occ_d         = occ_q;
        timeout_err_d = 1'b0;
        counted_entry = 1'b0;
        case (state_q)
            IDLE: begin
                // Exit wins outright when alone or when the lot is full
                if (exit_req && (!entry_req || full_q)) begin
                    state_d      = OPEN_OUT;
                    last_grant_d = EXIT;
                end else if (entry_req && !full_q) begin
                    if (exit_req && (last_grant_q == ENTRY)) begin
                        state_d      = OPEN_OUT;
                        last_grant_d = EXIT;
                    end else begin
                        state_d      = WAIT_AUTH;
                        last_grant_d = ENTRY;
                    end
                end
            end
            WAIT_AUTH: begin
                // Auth beats a coincident timeout
                if (entry_auth) begin
                    state_d = OPEN_IN;
                end else if (!entry_req) begin
                    state_d = IDLE;
                end else if (tmr_tc) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            OPEN_IN: begin
                // A passing car beats a coincident timeout
                if (car_passed) begin
                    if (occ_q != CAP)
                        occ_d = occ_q + 1'b1;
                    counted_entry = 1'b1;
                    state_d       = CLOSING;
                end else if (tmr_tc) begin
                    state_d       = CLOSING;
                    timeout_err_d = 1'b1;
                end
            end
            OPEN_OUT: begin
                if (car_passed) begin
                    if (occ_q != '0)
                        occ_d = occ_q - 1'b1;
                    state_d = CLOSING;
                end else if (tmr_tc) begin
                    state_d       = CLOSING;
                    timeout_err_d = 1'b1;
                end
            end
            CLOSING: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state being entered so outputs track it with no lag
    always_comb begin
        gate_open_d   = (state_d == OPEN_IN) || (state_d == OPEN_OUT);
        entry_grant_d = (state_d == WAIT_AUTH) || (state_d == OPEN_IN);
        exit_grant_d  = (state_d == OPEN_OUT);
        full_d        = (occ_d == CAP);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= EXIT;
            occ_q         <= '0;
            full_q        <= 1'b0;
            gate_open_q   <= 1'b0;
            entry_grant_q <= 1'b0;
            exit_grant_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            occ_q         <= occ_d;
            full_q        <= full_d;
            gate_open_q   <= gate_open_d;
            entry_grant_q <= entry_grant_d;
            exit_grant_q  <= exit_grant_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gate_open   = gate_open_q;
    assign entry_grant = entry_grant_q;
    assign exit_grant  = exit_grant_q;
    assign occupancy   = occ_q;
    assign full        = full_q;
    assign timeout_err = timeout_err_q;

`ifdef PARK_STATS_EN
    logic [15:0] total_entries_q, total_entries_d;
    logic [15:0] denied_full_q, denied_full_d;
    logic        entry_req_prev_q, entry_req_prev_d;

    // Counters wrap naturally; a denial is one new arrival while full
    always_comb begin
        entry_req_prev_d = entry_req;
        total_entries_d  = total_entries_q + {15'd0, counted_entry};
        denied_full_d    = denied_full_q
                         + {15'd0, (entry_req && !entry_req_prev_q && full_q)};
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            total_entries_q  <= '0;
            denied_full_q    <= '0;
            entry_req_prev_q <= 1'b0;
        end else begin
            total_entries_q  <= total_entries_d;
            denied_full_q    <= denied_full_d;
            entry_req_prev_q <= entry_req_prev_d;
        end
    end

    assign total_entries = total_entries_q;
    assign denied_full   = denied_full_q;
`endif

endmodule
